fetch_pc_queue: RTL and testbench

//  Decoupling queue between branch predictor PC generation and instruction-fetch stage.

---
 rtl/fetch_pc_queue_pkg.sv | 31 +++
 rtl/fetch_pc_queue_if.sv | 40 ++++
 rtl/fetch_pc_queue_id_alloc.sv | 36 +++
 rtl/fetch_pc_queue.sv | 83 ++++++++
 tb/tb_fetch_pc_queue.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/fetch_pc_queue_pkg.sv
// Shared types for the fetch PC queue: FetchID/offset widths, limit and mispredict
// descriptors, and the queued fetch packet.
package fetch_pc_queue_pkg;

    localparam int FETCH_ID_W  = 3;
    localparam int FETCH_OFF_W = 3;
    localparam int FQ_DEPTH    = 4;

    typedef logic [FETCH_ID_W-1:0]  FetchID_t;
    typedef logic [FETCH_OFF_W-1:0] FetchOff_t;

    typedef struct packed {
        logic     valid;
        FetchID_t fetchID;
    } FetchLimit;

    typedef struct packed {
        logic     taken;
        FetchID_t fetchID;
    } FetchBranchProv;

    typedef struct packed {
        logic [30:0] pc;
        FetchOff_t   lastOffs;
        logic        predValid;
        FetchOff_t   predOffs;
        logic        predTaken;
        FetchID_t    fetchID;
    } FetchQEntry;

endpackage

// File: rtl/fetch_pc_queue_if.sv
// Predictor-side and fetch-side signals of the fetch PC queue; slave is the queue's view.
interface fetch_pc_queue_if;
    import fetch_pc_queue_pkg::*;

    logic           IN_stall;
    FetchBranchProv IN_mispr;
    FetchLimit      IN_fetchLimit;
    FetchID_t       IN_comFetchID;
    logic [30:0]    IN_pc;
    FetchOff_t      IN_lastOffs;
    logic           IN_predValid;
    FetchOff_t      IN_predOffs;
    logic           IN_predTaken;
    logic           IN_ready;

    logic           OUT_pcValid;
    FetchID_t       OUT_fetchID;
    logic           OUT_valid;
    logic [30:0]    OUT_pc;
    FetchOff_t      OUT_lastOffs;
    logic           OUT_predValid;
    FetchOff_t      OUT_predOffs;
    logic           OUT_predTaken;
    FetchID_t       OUT_headID;

    modport master (
        output IN_stall, IN_mispr, IN_fetchLimit, IN_comFetchID, IN_pc, IN_lastOffs,
               IN_predValid, IN_predOffs, IN_predTaken, IN_ready,
        input  OUT_pcValid, OUT_fetchID, OUT_valid, OUT_pc, OUT_lastOffs,
               OUT_predValid, OUT_predOffs, OUT_predTaken, OUT_headID
    );

    modport slave (
        input  IN_stall, IN_mispr, IN_fetchLimit, IN_comFetchID, IN_pc, IN_lastOffs,
               IN_predValid, IN_predOffs, IN_predTaken, IN_ready,
        output OUT_pcValid, OUT_fetchID, OUT_valid, OUT_pc, OUT_lastOffs,
               OUT_predValid, OUT_predOffs, OUT_predTaken, OUT_headID
    );

endinterface

// File: rtl/fetch_pc_queue_id_alloc.sv
// FetchID allocator: next-ID counter, ring-full and pending-update guards, and
// reload from the mispredicting branch's ID.
module fetch_id_alloc
    import fetch_pc_queue_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  FetchBranchProv mispr,
    input  FetchLimit      fetchLimit,
    input  FetchID_t       comFetchID,
    input  logic           queueFull,
    output logic           accept,
    output FetchID_t       nextID
);

    FetchID_t idPlusOne;

    assign idPlusOne = nextID + FetchID_t'(1);

    // One ring slot stays free so the allocator never laps the oldest uncommitted ID.
    assign accept = !rst && !stall && !mispr.taken && !queueFull
                    && (idPlusOne != comFetchID)
                    && !(fetchLimit.valid && (nextID == fetchLimit.fetchID));

    always_ff @(posedge clk) begin
        if (rst) begin
            nextID <= '0;
        end else if (mispr.taken) begin
            nextID <= mispr.fetchID + FetchID_t'(1);
        end else if (accept) begin
            nextID <= idPlusOne;
        end
    end

endmodule

// File: rtl/fetch_pc_queue.sv
// In-order queue of predicted fetch packets between the branch predictor and fetch,
// tagging each packet with its FetchID and flushing on mispredict.
module fetch_pc_queue
    import fetch_pc_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    fetch_pc_queue_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

    FetchQEntry       mem [DEPTH];
    FetchQEntry       head;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;
    logic             accept;
    logic             pop;
    logic             full;
    FetchID_t         nextID;

    fetch_id_alloc idAlloc (
        .clk        (clk),
        .rst        (rst),
        .stall      (bus.IN_stall),
        .mispr      (bus.IN_mispr),
        .fetchLimit (bus.IN_fetchLimit),
        .comFetchID (bus.IN_comFetchID),
        .queueFull  (full),
        .accept     (accept),
        .nextID     (nextID)
    );

    assign full = (count == CNT_MAX);
    // A flush in the same cycle discards the pop; fetch re-reads after redirect.
    assign pop  = bus.OUT_valid && bus.IN_ready && !bus.IN_mispr.taken && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (bus.IN_mispr.taken) begin
            rdPtr <= wrPtr;
            count <= '0;
        end else begin
            if (accept) wrPtr <= wrPtr + PTR_ONE;
            if (pop)    rdPtr <= rdPtr + PTR_ONE;
            if (accept && !pop)      count <= count + CNT_ONE;
            else if (pop && !accept) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wrPtr] <= '{pc:        bus.IN_pc,
                            lastOffs:  bus.IN_lastOffs,
                            predValid: bus.IN_predValid,
                            predOffs:  bus.IN_predOffs,
                            predTaken: bus.IN_predTaken,
                            fetchID:   nextID};
        end
    end

    assign head = mem[rdPtr];

    assign bus.OUT_pcValid   = accept;
    assign bus.OUT_fetchID   = nextID;
    assign bus.OUT_valid     = (count != '0);
    assign bus.OUT_pc        = head.pc;
    assign bus.OUT_lastOffs  = head.lastOffs;
    assign bus.OUT_predValid = head.predValid;
    assign bus.OUT_predOffs  = head.predOffs;
    assign bus.OUT_predTaken = head.predTaken;
    assign bus.OUT_headID    = head.fetchID;

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue: stimulus pushes expected packets into a scoreboard,
// a negedge monitor pops and compares every head consumed by fetch.
module tb_fetch_pc_queue;
    import fetch_pc_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    FetchQEntry sb[$];
    FetchQEntry mon;

    fetch_pc_queue_if bus();

    fetch_pc_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one packet for a cycle, checks the predictor-side outputs at negedge.
    task automatic step(input logic [30:0] pc, input logic ready, input logic stall,
                        input logic expPcv, input FetchID_t expId);
        FetchQEntry e;
        e.pc        = pc;
        e.lastOffs  = pc[2:0] ^ 3'd5;
        e.predValid = pc[3];
        e.predOffs  = pc[4:2];
        e.predTaken = pc[5];
        e.fetchID   = expId;
        bus.IN_pc        = e.pc;
        bus.IN_lastOffs  = e.lastOffs;
        bus.IN_predValid = e.predValid;
        bus.IN_predOffs  = e.predOffs;
        bus.IN_predTaken = e.predTaken;
        bus.IN_ready     = ready;
        bus.IN_stall     = stall;
        @(negedge clk);
        chk("pcValid", 64'(bus.OUT_pcValid), 64'(expPcv));
        chk("fetchID", 64'(bus.OUT_fetchID), 64'(expId));
        if (expPcv) sb.push_back(e);
        if (rst || bus.IN_mispr.taken) sb.delete();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !bus.IN_mispr.taken && bus.OUT_valid && bus.IN_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL headUnexpected: got head id %0d expected no head", bus.OUT_headID);
            end else begin
                mon = sb.pop_front();
                chk("headPc", 64'(bus.OUT_pc), 64'(mon.pc));
                chk("headID", 64'(bus.OUT_headID), 64'(mon.fetchID));
                chk("headFields",
                    64'({bus.OUT_lastOffs, bus.OUT_predValid, bus.OUT_predOffs, bus.OUT_predTaken}),
                    64'({mon.lastOffs, mon.predValid, mon.predOffs, mon.predTaken}));
            end
        end
    end

    initial begin
        rst               = 1'b1;
        bus.IN_stall      = 1'b0;
        bus.IN_mispr      = '0;
        bus.IN_fetchLimit = '0;
        bus.IN_comFetchID = '0;
        bus.IN_pc         = '0;
        bus.IN_lastOffs   = '0;
        bus.IN_predValid  = 1'b0;
        bus.IN_predOffs   = '0;
        bus.IN_predTaken  = 1'b0;
        bus.IN_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rstOutValid", 64'(bus.OUT_valid), 64'(0));
        chk("rstPcValid", 64'(bus.OUT_pcValid), 64'(0));
        chk("rstNextID", 64'(bus.OUT_fetchID), 64'(0));
        rst = 1'b0;

        // streaming with fetch always ready
        for (int i = 0; i < 6; i++) step(31'h100 + 31'(4 * i), 1'b1, 1'b0, 1'b1, FetchID_t'(i));
        step(31'h0, 1'b1, 1'b1, 1'b0, 3'd6);
        chk("drainedValid", 64'(bus.OUT_valid), 64'(0));

        rst = 1'b1;
        step(31'h200, 1'b1, 1'b0, 1'b0, 3'd6);
        rst = 1'b0;

        // fill to DEPTH with fetch stalled
        for (int i = 0; i < 4; i++) step(31'h300 + 31'(4 * i), 1'b0, 1'b0, 1'b1, FetchID_t'(i));
        step(31'h310, 1'b0, 1'b0, 1'b0, 3'd4);
        step(31'h310, 1'b1, 1'b0, 1'b0, 3'd4);
        step(31'h314, 1'b0, 1'b0, 1'b1, 3'd4);

        // mispredict with IDs 2..4 queued
        step(31'h0, 1'b1, 1'b1, 1'b0, 3'd5);
        bus.IN_mispr = '{taken: 1'b1, fetchID: 3'd2};
        step(31'h400, 1'b1, 1'b0, 1'b0, 3'd5);
        bus.IN_mispr = '0;
        chk("flushValid", 64'(bus.OUT_valid), 64'(0));
        step(31'h0, 1'b1, 1'b1, 1'b0, 3'd3);
        step(31'h404, 1'b1, 1'b0, 1'b1, 3'd3);
        step(31'h0, 1'b1, 1'b1, 1'b0, 3'd4);

        // ring-full guard
        bus.IN_comFetchID = 3'd5;
        step(31'h500, 1'b1, 1'b0, 1'b0, 3'd4);
        bus.IN_comFetchID = 3'd6;
        step(31'h504, 1'b1, 1'b0, 1'b1, 3'd4);
        step(31'h0, 1'b1, 1'b1, 1'b0, 3'd5);

        // fetch limit, then wrap of the ID ring
        bus.IN_mispr = '{taken: 1'b1, fetchID: 3'd2};
        step(31'h600, 1'b1, 1'b0, 1'b0, 3'd5);
        bus.IN_mispr      = '0;
        bus.IN_fetchLimit = '{valid: 1'b1, fetchID: 3'd3};
        bus.IN_comFetchID = 3'd2;
        step(31'h604, 1'b1, 1'b0, 1'b0, 3'd3);
        bus.IN_fetchLimit = '0;
        for (int i = 3; i < 8; i++) step(31'h608 + 31'(4 * i), 1'b1, 1'b0, 1'b1, FetchID_t'(i));
        step(31'h0, 1'b1, 1'b1, 1'b0, 3'd0);

        // reset dominates a simultaneous mispredict with entries queued
        bus.IN_comFetchID = 3'd7;
        for (int i = 0; i < 3; i++) step(31'h700 + 31'(4 * i), 1'b0, 1'b0, 1'b1, FetchID_t'(i));
        chk("preRstValid", 64'(bus.OUT_valid), 64'(1));
        rst          = 1'b1;
        bus.IN_mispr = '{taken: 1'b1, fetchID: 3'd5};
        step(31'h720, 1'b1, 1'b0, 1'b0, 3'd3);
        rst          = 1'b0;
        bus.IN_mispr = '0;
        chk("postRstValid", 64'(bus.OUT_valid), 64'(0));
        step(31'h0, 1'b1, 1'b1, 1'b0, 3'd0);
        step(31'h724, 1'b1, 1'b0, 1'b1, 3'd0);
        repeat (4) step(31'h0, 1'b1, 1'b1, 1'b0, 3'd1);
        chk("scoreboardEmpty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
